// File: rtl/key_step_clkgen.sv
// key_step_clkgen: debounced pushbuttons to a glitch-free run/step processor clock.
// Define STEP_AUTOREPEAT_EN to add held-key step auto-repeat (REPEAT_CYCLES).
module key_step_clkgen #(
  parameter int DIV_W     = 24,
  parameter int DB_CYCLES = 250000,
  parameter int PULSE_W   = 8,
  parameter int CNT_W     = 32
`ifdef STEP_AUTOREPEAT_EN
  ,
  parameter int REPEAT_CYCLES = 5000000
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_step_n,
  input  logic             key_mode_n,
  input  logic [1:0]       speed,
  output logic             cpu_clk,
  output logic             run_mode,
  output logic             step_pulse,
  output logic [CNT_W-1:0] edge_count
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int PCW = $clog2(PULSE_W + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [PCW-1:0] P_LAST  = PCW'(PULSE_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    STEP_HIGH,
    RUN,
    DRAIN
  } state_e;

  // bit 0 = step key, bit 1 = mode key
  logic [1:0]          keys;
  logic [1:0]          s1_q, s2_q, db_q, press_q;
  logic [1:0][DBW-1:0] dbc_q;

  assign keys = {key_mode_n, key_step_n};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q    <= '1;
      s2_q    <= '1;
      db_q    <= '1;
      press_q <= '0;
      dbc_q   <= '0;
    end else begin
      s1_q <= keys;
      s2_q <= s1_q;
      for (int k = 0; k < 2; k++) begin
        press_q[k] <= 1'b0;
        if (s2_q[k] == db_q[k]) begin
          dbc_q[k] <= '0;
        end else if (dbc_q[k] == DB_LAST) begin
          db_q[k]    <= s2_q[k];
          dbc_q[k]   <= '0;
          press_q[k] <= ~s2_q[k];
        end else begin
          dbc_q[k] <= dbc_q[k] + 1'b1;
        end
      end
    end
  end

  logic [DIV_W-1:0] div_q;
  logic             tap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) div_q <= '0;
    else      div_q <= div_q + 1'b1;
  end

  always_comb begin
    tap = 1'b0;
    case (speed)
      2'd0: tap = div_q[DIV_W-1];
      2'd1: tap = div_q[DIV_W-3];
      2'd2: tap = div_q[DIV_W-5];
      2'd3: tap = div_q[DIV_W-7];
      default: tap = 1'b0;
    endcase
  end

  state_e           state_q, state_d;
  logic             cpu_q, cpu_d;
  logic             pend_q, pend_d;
  logic [PCW-1:0]   pcnt_q, pcnt_d;
  logic             run_q, sp_q;
  logic [CNT_W-1:0] ec_q;
  logic             mode_ev, step_ev;

  assign mode_ev = press_q[1];

`ifdef STEP_AUTOREPEAT_EN
  localparam int RCW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RCW-1:0] R_LAST = RCW'(REPEAT_CYCLES - 1);

  logic [RCW-1:0] rcnt_q;
  logic           rdue_q;
  logic           rpt_zone;

  assign rpt_zone = (state_q == IDLE) || (state_q == STEP_HIGH);
  // a repeat that falls due during the high phase waits for IDLE
  assign step_ev  = press_q[0] | (rdue_q & (state_q == IDLE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rcnt_q <= '0;
      rdue_q <= 1'b0;
    end else if (db_q[0] || !rpt_zone || step_ev) begin
      rcnt_q <= '0;
      rdue_q <= 1'b0;
    end else if (!rdue_q) begin
      if (rcnt_q == R_LAST) begin
        rcnt_q <= '0;
        rdue_q <= 1'b1;
      end else begin
        rcnt_q <= rcnt_q + 1'b1;
      end
    end
  end
`else
  assign step_ev = press_q[0];
`endif

  always_comb begin
    state_d = state_q;
    cpu_d   = 1'b0;
    pend_d  = pend_q;
    pcnt_d  = pcnt_q;
    unique case (state_q)
      IDLE: begin
        if (mode_ev) begin
          state_d = RUN;
        end else if (step_ev) begin
          state_d = STEP_HIGH;
          pcnt_d  = P_LAST;
          cpu_d   = 1'b1;
        end
      end
      STEP_HIGH: begin
        if (pcnt_q == '0) begin
          state_d = (pend_q | mode_ev) ? RUN : IDLE;
          pend_d  = 1'b0;
        end else begin
          pcnt_d = pcnt_q - 1'b1;
          pend_d = pend_q | mode_ev;
          cpu_d  = 1'b1;
        end
      end
      RUN: begin
        cpu_d = tap;
        if (mode_ev) begin
          if (cpu_q) begin
            state_d = DRAIN;
          end else begin
            state_d = IDLE;
            cpu_d   = 1'b0;
          end
        end
      end
      DRAIN: begin
        cpu_d = tap;
        if (!tap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cpu_q   <= 1'b0;
      pend_q  <= 1'b0;
      pcnt_q  <= '0;
      run_q   <= 1'b0;
      sp_q    <= 1'b0;
      ec_q    <= '0;
    end else begin
      state_q <= state_d;
      cpu_q   <= cpu_d;
      pend_q  <= pend_d;
      pcnt_q  <= pcnt_d;
      run_q   <= (state_d == RUN);
      sp_q    <= cpu_d & ~cpu_q;
      if (cpu_d & ~cpu_q) ec_q <= ec_q + 1'b1;
    end
  end

  assign cpu_clk    = cpu_q;
  assign run_mode   = run_q;
  assign step_pulse = sp_q;
  assign edge_count = ec_q;

endmodule
